// File: rtl/alu_share_arb.sv
// Round-robin sharing of one registered ALU between NUM_REQ requesters.
// Optional illegal-opcode check: define ALU_SHARE_ARB_OPCHK_EN.
module alu_share_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [32*NUM_REQ-1:0] req_a_i,
    input  logic [32*NUM_REQ-1:0] req_b_i,
    input  logic [4*NUM_REQ-1:0]  req_ctrl_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    input  logic [NUM_REQ-1:0]    rsp_ready_i,
    output logic [31:0]           rsp_data_o,
    output logic [31:0]           alu_a_o,
    output logic [31:0]           alu_b_o,
    output logic [3:0]            alu_ctrl_o,
`ifdef ALU_SHARE_ARB_OPCHK_EN
    output logic                  rsp_err_o,
`endif
    input  logic [31:0]           alu_out_i
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [IDX_W:0]   NR   = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   scan;
    logic             win_vld;
    logic             grant_en;
    logic             accept;
    logic             op_legal;
    logic [31:0]      win_a;
    logic [31:0]      win_b;
    logic [3:0]       win_ctrl;
`ifdef ALU_SHARE_ARB_OPCHK_EN
    logic             err_q;
`endif

    // Round-robin scan: first valid requester at or after rr_ptr
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan >= NR) begin
                scan = scan - NR;
            end
            if (!win_vld && req_valid_i[scan[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan[IDX_W-1:0];
            end
        end
    end

    assign win_a    = req_a_i[32*win_idx +: 32];
    assign win_b    = req_b_i[32*win_idx +: 32];
    assign win_ctrl = req_ctrl_i[4*win_idx +: 4];
    assign accept   = grant_en & win_vld;

`ifdef ALU_SHARE_ARB_OPCHK_EN
    // Opcode legality of the winning request
    always_comb begin
        op_legal = 1'b0;
        case (win_ctrl)
            4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
            4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101:
                op_legal = 1'b1;
            default:
                op_legal = 1'b0;
        endcase
    end
`else
    assign op_legal = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, grant enable and response outputs
    always_comb begin
        state_d     = state_q;
        grant_en    = 1'b0;
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        req_ready_o = '0;
`ifdef ALU_SHARE_ARB_OPCHK_EN
        rsp_err_o   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant_en = 1'b1;
                if (win_vld) begin
                    state_d = op_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                grant_en           = rsp_ready_i[owner];
                rsp_valid_o[owner] = 1'b1;
                rsp_data_o         = alu_out_i;
`ifdef ALU_SHARE_ARB_OPCHK_EN
                rsp_err_o = err_q;
                if (err_q) begin
                    rsp_data_o = '0;
                end
`endif
                if (rsp_ready_i[owner]) begin
                    if (win_vld) begin
                        state_d = op_legal ? EXEC : RESP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            req_ready_o = NUM_REQ'(1) << win_idx;
        end
    end

    // Capture operands, owner and pointer at each accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            owner      <= '0;
            alu_a_o    <= '0;
            alu_b_o    <= '0;
            alu_ctrl_o <= 4'b0000;
`ifdef ALU_SHARE_ARB_OPCHK_EN
            err_q      <= 1'b0;
`endif
        end else if (accept) begin
            owner  <= win_idx;
            rr_ptr <= (win_idx == LAST) ? '0 : win_idx + IDX_W'(1);
            if (op_legal) begin
                alu_a_o    <= win_a;
                alu_b_o    <= win_b;
                alu_ctrl_o <= win_ctrl;
            end
`ifdef ALU_SHARE_ARB_OPCHK_EN
            err_q <= ~op_legal;
`endif
        end
    end

endmodule
